// File: rtl/rtc_pkg.sv
// rtc_pkg: shared state encoding, RTC register map and default bus timing.
package rtc_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_A_SET = 3'd1;
  localparam logic [2:0] S_A_STB = 3'd2;
  localparam logic [2:0] S_A_HLD = 3'd3;
  localparam logic [2:0] S_D_SET = 3'd4;
  localparam logic [2:0] S_D_STB = 3'd5;
  localparam logic [2:0] S_D_HLD = 3'd6;
  localparam logic [2:0] S_GAP   = 3'd7;
  localparam logic [7:0] RTC_SEC   = 8'h20;
  localparam logic [7:0] RTC_MIN   = 8'h21;
  localparam logic [7:0] RTC_HOUR  = 8'h22;
  localparam logic [7:0] RTC_DAY   = 8'h23;
  localparam logic [7:0] RTC_MONTH = 8'h24;
  localparam logic [7:0] RTC_YEAR  = 8'h25;
  localparam logic [7:0] RTC_TSEC  = 8'h26;
  localparam logic [7:0] RTC_TMIN  = 8'h27;
  localparam logic [7:0] RTC_THOUR = 8'h28;
  localparam logic [7:0] RTC_CMD   = 8'h2f;
  localparam int DEF_T_SET = 2;
  localparam int DEF_T_STB = 6;
  localparam int DEF_T_HLD = 2;
  localparam int DEF_T_GAP = 4;
  localparam int DEF_CW    = 4;
  function automatic logic in_addr(input logic [2:0] s);
    return s >= S_A_SET && s <= S_A_HLD;
  endfunction
  function automatic logic in_data(input logic [2:0] s);
    return s >= S_D_SET && s <= S_D_HLD;
  endfunction
endpackage

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// phase_timer: loadable down-counter that flags the last cycle of a phase.
module phase_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero
);
  logic [CW-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (!zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: sequences single-byte RTC transactions on a muxed address/data bus.
module rtc_bus_ctrl import rtc_pkg::*; #(
  parameter int T_SET = DEF_T_SET,
  parameter int T_STB = DEF_T_STB,
  parameter int T_HLD = DEF_T_HLD,
  parameter int T_GAP = DEF_T_GAP,
  parameter int CW    = DEF_CW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_sel,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);
  logic [2:0] state, nxt;
  logic load, zero, take, rw_q, r_c, a_nx, d_nx;
  logic [CW-1:0] load_val;
  logic [7:0] addr_q, wdata_q, a_c, w_c;
  function automatic logic [CW-1:0] dur(input logic [2:0] s);
    return (s == S_A_SET || s == S_D_SET) ? CW'(T_SET - 1) :
           (s == S_A_STB || s == S_D_STB) ? CW'(T_STB - 1) :
           (s == S_A_HLD || s == S_D_HLD) ? CW'(T_HLD - 1) :
           (s == S_GAP) ? CW'(T_GAP - 1) : '0;
  endfunction
  assign take = state == S_IDLE && start;
  // outputs are registered from the next state, so use the request being accepted this cycle
  assign r_c  = take ? rw : rw_q;
  assign a_c  = take ? addr : addr_q;
  assign w_c  = take ? wdata : wdata_q;
  assign a_nx = in_addr(nxt);
  assign d_nx = in_data(nxt);
  always_comb begin
    nxt = take ? S_A_SET :
          (state != S_IDLE && zero) ? (state == S_GAP ? S_IDLE : state + 3'd1) : state;
    load = nxt != state;
    load_val = dur(nxt);
  end
  phase_timer #(.CW(CW)) u_timer (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .zero(zero)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= S_IDLE;
      rw_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      cs_n <= 1'b1;
      rd_n <= 1'b1;
      wr_n <= 1'b1;
      ad_sel <= 1'b1;
      ad_out <= '0;
      ad_oe <= 1'b0;
    end else begin
      state <= nxt;
      if (take) {rw_q, addr_q, wdata_q} <= {rw, addr, wdata};
      if (state == S_D_STB && zero && rw_q) rdata <= ad_in;
      busy <= nxt != S_IDLE;
      done <= state == S_D_HLD && nxt == S_GAP;
      cs_n <= !(a_nx || d_nx);
      ad_sel <= !d_nx;
      ad_oe <= a_nx || (d_nx && !r_c);
      ad_out <= a_nx ? a_c : (d_nx && !r_c) ? w_c : 8'h00;
      wr_n <= !(nxt == S_A_STB || (nxt == S_D_STB && !r_c));
      rd_n <= !(nxt == S_D_STB && r_c);
    end
endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// tb_rtc_bus_ctrl: directed bench with a done-time scoreboard for rtc_bus_ctrl.
module tb_rtc_bus_ctrl;
  localparam int T_SET = 2, T_STB = 6, T_HLD = 2, T_GAP = 4;
  localparam int LEN = 2 * (T_SET + T_STB + T_HLD) + 1;
  logic clk = 0, reset = 1, start = 0, rw = 0;
  logic [7:0] addr = 0, wdata = 0, ad_in = 0;
  logic [7:0] rdata, ad_out;
  logic busy, done, cs_n, rd_n, wr_n, ad_sel, ad_oe;
  int vectors = 0, errs = 0, cyc = 0;
  logic [7:0] mrd = 0;
  logic [7:0] exp_rd[$];
  int exp_cyc[$];

  rtc_bus_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .ad_sel(ad_sel), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("strobe_safe", {1'b0, !(!rd_n && !wr_n) && !((!rd_n || !wr_n) && cs_n)}, 2'b01);
    if (done) begin
      if (exp_cyc.size() == 0) chk("done_unexp", {31'b0, done}, 32'd0);
      else begin
        chk("done_cyc", cyc, exp_cyc.pop_front());
        chk("done_rdata", {24'b0, rdata}, {24'b0, exp_rd.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_chk(input string tag);
    chk(tag, {cs_n, rd_n, wr_n, ad_sel, ad_oe, busy, done, rdata, ad_out},
        {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
  endtask

  task automatic txn(input logic r, input logic [7:0] a, input logic [7:0] w,
                     input logic [7:0] d, input bit poke);
    int done_at = -1, busy_at = -1, ndone = 0, wa = 0, wd = 0, rl = 0, oe_d = 0, cs_hi = 0;
    bit seen_rd = 0;
    rw = r; addr = a; wdata = w; ad_in = d; start = 1;
    exp_rd.push_back(r ? d : mrd);
    exp_cyc.push_back(cyc + LEN);
    if (r) mrd = d;
    for (int i = 1; i <= 40 && busy_at < 0; i++) begin
      tick();
      start = poke && (i == 3 || i == 10);
      if (start) begin rw = !r; addr = 8'hee; wdata = 8'hee; end
      if (done) begin ndone++; if (done_at < 0) done_at = i; end
      if (!wr_n && ad_sel && ad_out == a) wa++;
      if (!wr_n && !ad_sel && ad_out == w) wd++;
      if (!rd_n && !ad_sel && !ad_oe) rl++;
      if (!rd_n) seen_rd = 1; else if (seen_rd) ad_in = 8'h99;
      if (!cs_n && !ad_sel && ad_oe) oe_d++;
      if (cs_n) cs_hi++;
      if (i == 1) chk("first_cyc", {22'b0, cs_n, ad_sel, ad_out}, {22'b0, 1'b0, 1'b1, a});
      if (!busy) busy_at = i;
    end
    chk("done_at", done_at, LEN);
    chk("busy_at", busy_at, LEN + T_GAP);
    chk("done_count", ndone, 1);
    chk("wr_addr_cycles", wa, T_STB);
    chk("wr_data_cycles", wd, r ? 0 : T_STB);
    chk("rd_cycles", rl, r ? T_STB : 0);
    chk("data_oe_cycles", oe_d, r ? 0 : T_SET + T_STB + T_HLD);
    chk("cs_high_gap", cs_hi, T_GAP + 1);
    chk("rdata_held", {24'b0, rdata}, {24'b0, mrd});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    for (int i = 0; i < 10; i++) begin tick(); idle_chk("idle_after_reset"); end
    txn(1'b0, 8'h21, 8'h45, 8'h00, 1'b0);
    txn(1'b1, 8'h22, 8'h00, 8'h37, 1'b0);
    tick(); tick();
    txn(1'b0, 8'h26, 8'h10, 8'h00, 1'b1);
    txn(1'b1, 8'h27, 8'h00, 8'ha5, 1'b0);
    tick();
    rw = 0; addr = 8'h23; wdata = 8'h55; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 30 && !(!wr_n && !ad_sel); i++) tick();
    chk("reached_d_stb", {30'b0, wr_n, ad_sel}, 32'd0);
    #2 reset = 1;
    #1 chk("abort_async", {29'b0, cs_n, wr_n, rd_n}, 32'd7);
    exp_rd.delete();
    exp_cyc.delete();
    mrd = 8'h00;
    tick();
    reset = 0;
    for (int i = 0; i < 5; i++) begin tick(); idle_chk("idle_after_abort"); end
    txn(1'b1, 8'h24, 8'h00, 8'h5a, 1'b0);
    repeat (3) tick();
    chk("queue_drained", exp_cyc.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/rtc_bus_ctrl.md
Name: rtc_bus_ctrl

Overview:
- Sequences single-byte read/write transactions on the RTC chip's multiplexed address/data bus for the PicoBlaze clock/timer subsystem.
- The PicoBlaze side issues one request (address, data, direction); the block drives cs_n/rd_n/wr_n/ad_sel and the AD byte with programmable phase timing.
- It returns the read byte with a done pulse. The PicoBlaze then forwards the byte to the VGA display registers through the port decoder.

Parameters:
- T_SET, 2, cycles of setup before each strobe (min 1)
- T_STB, 6, cycles a strobe (rd_n/wr_n) is held low (min 1)
- T_HLD, 2, cycles of hold after each strobe (min 1)
- T_GAP, 4, recovery cycles with cs_n high after a transaction, before busy drops (min 1)
- CW, 4, counter width; must hold max(T_SET,T_STB,T_HLD,T_GAP)-1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request strobe, accepted only when busy=0
- rw  in  1  1=read, 0=write; sampled with start
- addr  in  8  RTC register address; sampled with start
- wdata  in  8  write byte; sampled with start
- rdata  out  8  last byte read from RTC
- busy  out  1  transaction in progress (includes gap)
- done  out  1  one-cycle pulse at end of data hold
- cs_n  out  1  RTC chip select, active low
- rd_n  out  1  read strobe, active low
- wr_n  out  1  write strobe, active low
- ad_sel  out  1  1=address phase, 0=data phase
- ad_out  out  8  byte driven onto AD bus
- ad_oe  out  1  1=block drives AD (tri-state enable for top level)
- ad_in  in  8  AD bus value from pad

Behaviour:
- One clock (clk); reset asynchronous, active-high. All outputs are registered (glitch-free strobes).
- Reset values: cs_n=1, rd_n=1, wr_n=1, ad_sel=1, ad_oe=0, ad_out=0, rdata=0, busy=0, done=0. State=IDLE, counter=0.
- Asserting reset mid-transaction aborts it immediately. Strobes and cs_n go high asynchronously, and no done pulse is issued.
- FSM states, each held for its parameter count via the down-counter:
  - IDLE
  - A_SET(T_SET)
  - A_STB(T_STB)
  - A_HLD(T_HLD)
  - D_SET(T_SET)
  - D_STB(T_STB)
  - D_HLD(T_HLD)
  - GAP(T_GAP)
  - then back to IDLE.
- IDLE: when start=1, latch rw/addr/wdata, set busy=1, go to A_SET next cycle. start while busy=1 is ignored (no queueing).
- Address phase (A_SET..A_HLD):
  - cs_n=0, ad_sel=1, ad_oe=1, ad_out=addr.
  - wr_n=0 only during A_STB; the address is always written.
- Data phase (D_SET..D_HLD):
  - cs_n=0, ad_sel=0.
  - Write: ad_oe=1, ad_out=wdata, wr_n=0 during D_STB.
  - Read: ad_oe=0, ad_out=0, rd_n=0 during D_STB.
- Read sampling: rdata <= ad_in on the last cycle of D_STB. rdata is otherwise held, including across writes.
- done=1 for exactly one cycle, on the first cycle of GAP. cs_n=1, ad_oe=0, ad_sel=1 throughout GAP.
- busy drops on the first IDLE cycle. A start in that same cycle is accepted, giving back-to-back requests.
- rd_n and wr_n are never low simultaneously. No strobe is ever low while cs_n=1.
- ad_oe never transitions in the same cycle a strobe falls (guaranteed by T_SET ≥ 1).
- Transaction length: start to done = 2·(T_SET+T_STB+T_HLD)+1 cycles (defaults: 21). start to busy low = that + T_GAP (defaults: 25).

Decomposition:
- Shared package rtc_pkg:
  - FSM state encoding (8 states, 3 bits)
  - RTC register address constants (seconds, minutes, hours, day, month, year, timer sec/min/hour, command)
  - default timing constants
- Sub-module phase_timer:
  - loadable down-counter with load value and zero flag
  - instantiated once, reloaded on each state entry

Test Plan:
- Reset, then idle 10 cycles -> cs_n=rd_n=wr_n=1, ad_oe=0, busy=0, rdata=0, done never asserted.
- Write addr=0x21, wdata=0x45 (defaults):
  - wr_n low 6 cycles with ad_sel=1, ad_out=0x21, then 6 cycles with ad_sel=0, ad_out=0x45.
  - done 21 cycles after start; busy low at cycle 25.
- Read addr=0x22, ad_in=0x37 in data phase:
  - rd_n low 6 cycles, ad_oe=0 during data phase, rdata=0x37 at done.
  - ad_in changed to 0x99 after D_STB -> rdata stays 0x37.
- start pulsed again at cycles 3 and 10 of an active transaction -> ignored; exactly one done, latched addr unchanged.
- reset asserted during D_STB of a write -> wr_n, cs_n high immediately; no done; a new read after reset completes normally.
- Back-to-back: second start on the first IDLE cycle -> accepted. Second address phase begins next cycle; cs_n high for exactly T_GAP+1 cycles between transactions.
